// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl: interrupt priority and acknowledge controller for the MFP.
// Takes the 16 pending bits, applies mask and in-service nesting, drives irq,
// and runs the IACK handshake. Each acknowledge returns a vector and one
// clear pulse to the pending bank.
//
// Handshake: the CPU raises iack and holds it for the whole IACK cycle. The
// rising edge of iack, seen while irq=1, latches the winning channel. From
// the following cycle until the first cycle that samples iack=0, vector is
// stable and flagged by vector_valid.
module mfp_irq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ipr,
  input  logic [15:0] imr,
  input  logic [7:0]  vr,
  input  logic        iack,
  input  logic        isr_wr,
  input  logic [15:0] isr_wdata,
  output logic        irq,
  output logic [7:0]  vector,
  output logic        vector_valid,
  output logic [15:0] ipr_clr,
  output logic [15:0] isr
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state;
  logic        iack_d;
  logic [15:0] active;
  logic [3:0]  hp;
  logic [3:0]  hs;
  logic        hs_valid;
  logic        request;
  logic        ack_edge;
  logic        ack_take;
  logic [15:0] isr_next;

  assign active = ipr & imr;

  // Highest-priority pending channel and highest in-service channel.
  always_comb begin
    hp       = 4'd0;
    hs       = 4'd0;
    hs_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (active[i]) hp = i[3:0];
      if (isr[i]) begin
        hs       = i[3:0];
        hs_valid = 1'b1;
      end
    end
  end

  // A channel requests only if it outranks everything currently in service.
  assign request  = (active != 16'h0000) && (!hs_valid || (hp > hs));
  assign ack_edge = (state == IDLE) && iack && !iack_d;
  assign ack_take = ack_edge && irq;

  // In-service update: CPU clear first, acknowledge set second, so the set
  // wins on the acknowledged bit; automatic EOI keeps the register empty.
  always_comb begin
    isr_next = isr;
    if (isr_wr) isr_next = isr_next & isr_wdata;
    if (ack_take) isr_next[hp] = 1'b1;
    if (!vr[3]) isr_next = 16'h0000;
  end

  // Acknowledge FSM with registered irq, vector, clear pulse and isr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      iack_d       <= 1'b0;
      irq          <= 1'b0;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      ipr_clr      <= 16'h0000;
      isr          <= 16'h0000;
    end else begin
      iack_d  <= iack;
      irq     <= request && (state == IDLE);
      ipr_clr <= 16'h0000;
      isr     <= isr_next;
      case (state)
        IDLE: begin
          if (ack_edge) begin
            state <= HOLD;
            if (irq) begin
              vector       <= {vr[7:4], hp};
              vector_valid <= 1'b1;
              ipr_clr      <= 16'h0001 << hp;
            end
          end
        end
        HOLD: begin
          if (!iack) begin
            vector_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// Directed testbench for mfp_irq_ctrl.
module tb_mfp_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ipr;
  logic [15:0] imr;
  logic [7:0]  vr;
  logic        iack;
  logic        isr_wr;
  logic [15:0] isr_wdata;
  logic        irq;
  logic [7:0]  vector;
  logic        vector_valid;
  logic [15:0] ipr_clr;
  logic [15:0] isr;

  int checks = 0;
  int errors = 0;

  mfp_irq_ctrl dut (
    .clk(clk), .reset(reset), .ipr(ipr), .imr(imr), .vr(vr), .iack(iack),
    .isr_wr(isr_wr), .isr_wdata(isr_wdata), .irq(irq), .vector(vector),
    .vector_valid(vector_valid), .ipr_clr(ipr_clr), .isr(isr)
  );

  // Clock
  always #5 clk = ~clk;

  // One active edge, then settle; inputs changed after this land on the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ipr = 16'hFFFF; imr = 16'hFFFF; vr = 8'h40;
    iack = 1'b0; isr_wr = 1'b0; isr_wdata = 16'hFFFF;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL rst_vv: got %b expected 0", vector_valid); end
    checks++; if (isr !== 16'h0000) begin errors++; $display("FAIL rst_isr: got %h expected 0000", isr); end
    checks++; if (ipr_clr !== 16'h0000) begin errors++; $display("FAIL rst_clr: got %h expected 0000", ipr_clr); end
    checks++; if (vector !== 8'h00) begin errors++; $display("FAIL rst_vector: got %h expected 00", vector); end
    reset = 1'b0;
    tick(); tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rst_release_irq: got %b expected 1", irq); end
    ipr = 16'h0000;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_idle_irq: got %b expected 0", irq); end
  endtask

  task automatic test_priority();
    ipr = 16'h0441; imr = 16'hFFFF; vr = 8'h40;
    tick(); tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pri_irq: got %b expected 1", irq); end
    iack = 1'b1;
    tick();
    checks++; if (vector !== 8'h4A) begin errors++; $display("FAIL pri_vector: got %h expected 4a", vector); end
    checks++; if (ipr_clr !== 16'h0400) begin errors++; $display("FAIL pri_clr: got %h expected 0400", ipr_clr); end
    checks++; if (vector_valid !== 1'b1) begin errors++; $display("FAIL pri_vv: got %b expected 1", vector_valid); end
    checks++; if (isr !== 16'h0000) begin errors++; $display("FAIL pri_isr: got %h expected 0000", isr); end
    ipr = 16'h0041;
    tick();
    checks++; if (ipr_clr !== 16'h0000) begin errors++; $display("FAIL pri_clr_width: got %h expected 0000", ipr_clr); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pri_irq_hold: got %b expected 0", irq); end
    checks++; if (vector_valid !== 1'b1) begin errors++; $display("FAIL pri_vv_hold: got %b expected 1", vector_valid); end
    iack = 1'b0;
    tick();
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL pri_vv_drop: got %b expected 0", vector_valid); end
    checks++; if (vector !== 8'h4A) begin errors++; $display("FAIL pri_vector_keep: got %h expected 4a", vector); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pri_irq_return: got %b expected 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pri_irq_reassert: got %b expected 1", irq); end
    ipr = 16'h0000;
    tick(); tick();
  endtask

  task automatic test_mask();
    ipr = 16'h0010; imr = 16'h0000;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq_off: got %b expected 0", irq); end
    imr = 16'h0010;
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL mask_irq_on: got %b expected 1", irq); end
    iack = 1'b1;
    tick();
    checks++; if (vector !== 8'h44) begin errors++; $display("FAIL mask_vector: got %h expected 44", vector); end
    checks++; if (ipr_clr !== 16'h0010) begin errors++; $display("FAIL mask_clr: got %h expected 0010", ipr_clr); end
    ipr = 16'h0000; imr = 16'hFFFF;
    tick();
    iack = 1'b0;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_idle: got %b expected 0", irq); end
  endtask

  task automatic test_s_mode();
    vr = 8'h48; ipr = 16'h0020;
    tick(); tick();
    iack = 1'b1;
    tick();
    checks++; if (vector !== 8'h45) begin errors++; $display("FAIL s_vector: got %h expected 45", vector); end
    checks++; if (isr !== 16'h0020) begin errors++; $display("FAIL s_isr_set: got %h expected 0020", isr); end
    ipr = 16'h0000;
    tick();
    iack = 1'b0;
    tick(); tick();
    ipr = 16'h0008;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL s_lower_blocked: got %b expected 0", irq); end
    ipr = 16'h0208;
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL s_higher_nests: got %b expected 1", irq); end
    ipr = 16'h0008;
    tick();
    isr_wr = 1'b1; isr_wdata = 16'hFFDF;
    tick();
    isr_wr = 1'b0; isr_wdata = 16'hFFFF;
    checks++; if (isr !== 16'h0000) begin errors++; $display("FAIL s_isr_clear: got %h expected 0000", isr); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL s_ch3_requests: got %b expected 1", irq); end
    iack = 1'b1;
    tick();
    checks++; if (vector !== 8'h43) begin errors++; $display("FAIL s_ch3_vector: got %h expected 43", vector); end
    checks++; if (isr !== 16'h0008) begin errors++; $display("FAIL s_ch3_isr: got %h expected 0008", isr); end
    ipr = 16'h0000;
    tick();
    iack = 1'b0; isr_wr = 1'b1; isr_wdata = 16'h0000;
    tick();
    isr_wr = 1'b0; isr_wdata = 16'hFFFF;
    tick();
  endtask

  task automatic test_spurious_abort();
    iack = 1'b1;
    tick();
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL spur_vv: got %b expected 0", vector_valid); end
    checks++; if (ipr_clr !== 16'h0000) begin errors++; $display("FAIL spur_clr: got %h expected 0000", ipr_clr); end
    checks++; if (vector !== 8'h43) begin errors++; $display("FAIL spur_vector_keep: got %h expected 43", vector); end
    ipr = 16'h0001;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL spur_hold_irq: got %b expected 0", irq); end
    iack = 1'b0;
    tick(); tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL spur_return_irq: got %b expected 1", irq); end
    iack = 1'b1;
    tick();
    checks++; if (vector_valid !== 1'b1) begin errors++; $display("FAIL abort_vv_set: got %b expected 1", vector_valid); end
    checks++; if (vector !== 8'h40) begin errors++; $display("FAIL abort_vector: got %h expected 40", vector); end
    reset = 1'b1;
    tick();
    checks++; if (vector_valid !== 1'b0) begin errors++; $display("FAIL abort_vv: got %b expected 0", vector_valid); end
    checks++; if (ipr_clr !== 16'h0000) begin errors++; $display("FAIL abort_clr: got %h expected 0000", ipr_clr); end
    checks++; if (isr !== 16'h0000) begin errors++; $display("FAIL abort_isr: got %h expected 0000", isr); end
    reset = 1'b0; iack = 1'b0; ipr = 16'h0000;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL abort_idle_irq: got %b expected 0", irq); end
  endtask

  task automatic test_simultaneous();
    vr = 8'h48; ipr = 16'h0002;
    tick(); tick();
    iack = 1'b1;
    tick();
    checks++; if (isr !== 16'h0002) begin errors++; $display("FAIL sim_pre_isr: got %h expected 0002", isr); end
    ipr = 16'h0000;
    tick();
    iack = 1'b0;
    tick();
    ipr = 16'h0080;
    tick(); tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sim_irq: got %b expected 1", irq); end
    iack = 1'b1; isr_wr = 1'b1; isr_wdata = 16'h0000;
    tick();
    isr_wr = 1'b0; isr_wdata = 16'hFFFF;
    checks++; if (isr !== 16'h0080) begin errors++; $display("FAIL sim_isr: got %h expected 0080", isr); end
    checks++; if (vector !== 8'h47) begin errors++; $display("FAIL sim_vector: got %h expected 47", vector); end
    ipr = 16'h0000;
    tick();
    iack = 1'b0;
    vr = 8'h40;
    tick();
    checks++; if (isr !== 16'h0000) begin errors++; $display("FAIL auto_eoi_isr: got %h expected 0000", isr); end
    tick();
  endtask

  task automatic test_back_to_back();
    vr = 8'h90; ipr = 16'h0003;
    tick(); tick();
    iack = 1'b1;
    tick();
    checks++; if (vector !== 8'h91) begin errors++; $display("FAIL b2b_first: got %h expected 91", vector); end
    checks++; if (ipr_clr !== 16'h0002) begin errors++; $display("FAIL b2b_first_clr: got %h expected 0002", ipr_clr); end
    ipr = 16'h0001;
    tick();
    iack = 1'b0;
    tick(); tick();
    iack = 1'b1;
    tick();
    checks++; if (vector !== 8'h90) begin errors++; $display("FAIL b2b_second: got %h expected 90", vector); end
    checks++; if (ipr_clr !== 16'h0001) begin errors++; $display("FAIL b2b_second_clr: got %h expected 0001", ipr_clr); end
    ipr = 16'h0000;
    tick();
    iack = 1'b0;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", irq); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_mask();
    test_s_mode();
    test_spurious_abort();
    test_simultaneous();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
